register_bank: RTL

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_pkg.sv | 15 +
 rtl/register_merge.sv | 24 ++
 rtl/register_bank.sv | 99 +++++++++
 3 files changed

// File: rtl/register_pkg.sv
// Shared types for the register bank: write-mode encoding and address sizing.
package register_pkg;

   typedef enum logic [1:0] {
      WM_LOAD   = 2'd0,
      WM_SET    = 2'd1,
      WM_CLEAR  = 2'd2,
      WM_TOGGLE = 2'd3
   } wmode_t;

   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/register_merge.sv
// Combinational merge of an old entry value with a write operand.
module register_merge
   import register_pkg::*;
#(
   parameter int unsigned P_width = 8
) (
   input  logic [P_width-1:0] I_old,
   input  logic [P_width-1:0] I_bits,
   input  wmode_t             I_mode,
   output logic [P_width-1:0] O_value
);

   always_comb begin
      O_value = I_bits;
      unique case (I_mode)
         WM_LOAD:   O_value = I_bits;
         WM_SET:    O_value = I_old | I_bits;
         WM_CLEAR:  O_value = I_old & ~I_bits;
         WM_TOGGLE: O_value = I_old ^ I_bits;
         default:   O_value = I_bits;
      endcase
   end

endmodule

// File: rtl/register_bank.sv
// Flip-flop register bank with bitwise write modes, shadow snapshot/restore,
// optional write-to-read forwarding and a registered content-changed pulse.
module register_bank
   import register_pkg::*;
#(
   parameter int unsigned          P_width  = 8,
   parameter int unsigned          P_depth  = 4,
   parameter logic [P_width-1:0]   P_init   = '0,
   parameter bit                   P_bypass = 1'b1,
   localparam int unsigned         AW       = addr_width(P_depth)
) (
   input  logic               I_clock,
   input  logic               I_reset,
   input  logic               I_write,
   input  logic [AW-1:0]      I_waddr,
   input  logic [1:0]         I_wmode,
   input  logic [P_width-1:0] I_bits,
   input  logic               I_snapshot,
   input  logic               I_restore,
   input  logic [AW-1:0]      I_raddr_a,
   input  logic [AW-1:0]      I_raddr_b,
   output logic [P_width-1:0] O_bits_a,
   output logic [P_width-1:0] O_bits_b,
   output logic               O_changed
);

   logic [P_width-1:0] r_entries [P_depth];
   logic [P_width-1:0] r_shadow  [P_depth];
   logic               r_changed;

   logic [P_width-1:0] w_next    [P_depth];
   logic [P_width-1:0] w_old;
   logic [P_width-1:0] w_merged;
   logic               w_waddr_ok;
   logic               w_fwd;
   logic               w_changed;

   function automatic logic in_range(input logic [AW-1:0] addr);
      return 32'(addr) < P_depth;
   endfunction

   assign w_waddr_ok = in_range(I_waddr);
   assign w_old      = w_waddr_ok ? r_entries[I_waddr] : '0;
   assign w_fwd      = P_bypass && I_write && !I_restore && !I_reset && w_waddr_ok;

   // Single merge instance: its result feeds both the stored write and forwarding.
   register_merge #(.P_width(P_width)) u_merge (
      .I_old   (w_old),
      .I_bits  (I_bits),
      .I_mode  (wmode_t'(I_wmode)),
      .O_value (w_merged)
   );

   always_comb begin
      w_changed = 1'b0;
      for (int unsigned i = 0; i < P_depth; i++) begin
         w_next[i] = r_entries[i];
         if (I_restore)
            w_next[i] = r_shadow[i];
         else if (I_write && w_waddr_ok && (32'(I_waddr) == i))
            w_next[i] = w_merged;
         if (w_next[i] != r_entries[i])
            w_changed = 1'b1;
      end
   end

   always_ff @(posedge I_clock) begin
      if (I_reset) begin
         for (int unsigned i = 0; i < P_depth; i++) begin
            r_entries[i] <= P_init;
            r_shadow[i]  <= P_init;
         end
         r_changed <= 1'b0;
      end else begin
         // Shadow takes pre-edge entries while entries take the old shadow: a swap.
         for (int unsigned i = 0; i < P_depth; i++) begin
            r_entries[i] <= w_next[i];
            if (I_snapshot)
               r_shadow[i] <= r_entries[i];
         end
         r_changed <= w_changed;
      end
   end

   always_comb begin
      O_bits_a = '0;
      if (in_range(I_raddr_a))
         O_bits_a = (w_fwd && (I_raddr_a == I_waddr)) ? w_merged : r_entries[I_raddr_a];
   end

   always_comb begin
      O_bits_b = '0;
      if (in_range(I_raddr_b))
         O_bits_b = (w_fwd && (I_raddr_b == I_waddr)) ? w_merged : r_entries[I_raddr_b];
   end

   assign O_changed = r_changed;

endmodule
